// File: rtl/bcd_serial_adder.sv
// Serial multi-digit BCD adder/subtractor with a start/busy/done handshake.
// One digit is resolved per clock, least significant first. Operands are
// screened for non-decimal digits at accept time, and such operands
// short-circuit straight to the result state.

// Flags a single BCD digit that is outside 0..9.
module bcd_digit_chk (
  input  logic [3:0] d,
  output logic       bad
);
  assign bad = (d > 4'd9);
endmodule

// One decimal digit slice. In subtract mode b is nine's-complemented, and the
// initial carry of 1 turns that into ten's complement.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] bp;
  logic [4:0] raw;

  // The raw digit sum is at most 9+9+1 = 19, so a single -10 correction is enough.
  always_comb begin
    bp  = sub ? (4'd9 - b) : b;
    raw = {1'b0, a} + {1'b0, bp} + {4'b0, ci};
    if (raw > 5'd9) begin
      s  = 4'(raw - 5'd10);
      co = 1'b1;
    end else begin
      s  = raw[3:0];
      co = 1'b0;
    end
  end
endmodule

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] a;
    logic [DIGITS-1:0][3:0] b;
    logic                   sub;
  } opnd_t;

  state_t                 state, state_nxt;
  opnd_t                  op_q;
  logic                   carry_q;
  logic [IW-1:0]          idx_q;
  logic [DIGITS-1:0][3:0] work_q, work_nxt;
  logic [DIGITS-1:0]      bad_a, bad_b;
  logic                   any_bad;
  logic                   last;
  logic [3:0]             dig;
  logic                   dco;

  // Per-digit range checks on the live inputs; they only matter at the accept edge.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_chk
      bcd_digit_chk u_chk_a (.d(a[4*g +: 4]), .bad(bad_a[g]));
      bcd_digit_chk u_chk_b (.d(b[4*g +: 4]), .bad(bad_b[g]));
    end
  endgenerate

  assign any_bad = |{bad_a, bad_b};
  assign last    = (idx_q == IW'(DIGITS - 1));

  // One shared digit slice walks across the latched operands.
  bcd_digit_add u_add (
    .a  (op_q.a[idx_q]),
    .b  (op_q.b[idx_q]),
    .sub(op_q.sub),
    .ci (carry_q),
    .s  (dig),
    .co (dco)
  );

  // Working register with the current digit merged in; the final merge goes straight to sum.
  always_comb begin
    work_nxt        = work_q;
    work_nxt[idx_q] = dig;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE, so requests during ADD/DONE are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = any_bad ? DONE : ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

  // Datapath: latch the operands on accept, ripple one digit per ADD cycle, and publish results on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q.a   <= a;
            op_q.b   <= b;
            op_q.sub <= sub;
            carry_q  <= sub ? 1'b1 : cin;
            idx_q    <= '0;
            work_q   <= '0;
            if (any_bad) begin
              sum     <= '0;
              cout    <= 1'b0;
              invalid <= 1'b1;
            end else begin
              invalid <= 1'b0;
            end
          end
        end
        ADD: begin
          work_q  <= work_nxt;
          carry_q <= dco;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            sum  <= work_nxt;
            cout <= dco;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: a 4-digit and a 1-digit instance share the operand
// buses. Results are predicted by plain decimal arithmetic on the operand values.
module tb_bcd_serial_adder;
  logic        clk = 1'b0;
  logic        rst4, rst1, start4, start1, sub, cin;
  logic [15:0] a, b;
  logic        busy4, done4, cout4, inv4;
  logic [15:0] sum4;
  logic        busy1, done1, cout1, inv1;
  logic [3:0]  sum1;
  logic [15:0] held4, held1;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .invalid(inv4));

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .sub(sub), .a(a[3:0]), .b(b[3:0]), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .invalid(inv1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [15:0] x, input int d);
    longint v = 0;
    for (int i = d - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input longint v, input int d);
    logic [15:0] s = '0;
    for (int i = 0; i < d; i++) begin
      s[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return s;
  endfunction

  // Decimal reference: subtraction is A + (10^d - B), which carries out exactly when A >= B.
  task automatic model(input logic [15:0] av, input logic [15:0] bv, input bit s, input bit c,
                       input int d, output logic [15:0] es, output bit eco, output bit einv);
    longint m = 1;
    longint tot;
    einv = 0;
    for (int i = 0; i < d; i++) begin
      if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) einv = 1;
      m = m * 10;
    end
    if (einv) begin
      es = '0; eco = 0;
    end else begin
      tot = s ? bcd2int(av, d) + m - bcd2int(bv, d) : bcd2int(av, d) + bcd2int(bv, d) + longint'(c);
      eco = (tot >= m);
      es  = int2bcd(tot % m, d);
    end
  endtask

  function automatic logic [15:0] rand_bcd(input int d, input bit allow_bad);
    logic [15:0] v = '0;
    for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0)
      v[4*$urandom_range(0, d - 1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // One full transaction on the chosen instance, checking latency, busy length, hold and results.
  task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                        input bit s, input bit c, input string tag);
    logic [15:0] es, cs;
    bit          eco, einv;
    int          cyc, bcnt;
    model(av, bv, s, c, d, es, eco, einv);
    @(negedge clk);
    a = av; b = bv; sub = s; cin = c;
    if (d == 4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start1 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    cyc = 1; bcnt = 0;
    while (!((d == 4) ? done4 : done1) && cyc < 20) begin
      if ((d == 4) ? busy4 : busy1) bcnt++;
      cs = (d == 4) ? sum4 : {12'h0, sum1};
      chk({tag, " hold"}, cs, (d == 4) ? held4 : held1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, einv ? 1 : d + 1);
    chk({tag, " busycnt"}, bcnt, einv ? 0 : d);
    cs = (d == 4) ? sum4 : {12'h0, sum1};
    chk({tag, " sum"}, cs, es);
    chk({tag, " cout"}, (d == 4) ? cout4 : cout1, eco);
    chk({tag, " invalid"}, (d == 4) ? inv4 : inv1, einv);
    @(negedge clk);
    chk({tag, " donepulse"}, (d == 4) ? done4 : done1, 1'b0);
    if (d == 4) held4 = es; else held1 = es;
  endtask

  initial begin
    logic [15:0] es;
    bit          eco, einv;
    rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b0; start1 = 1'b0;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    held4 = '0; held1 = '0;
    repeat (2) @(negedge clk);
    chk("rst busy4", busy4, 0);  chk("rst done4", done4, 0);
    chk("rst sum4", sum4, 0);    chk("rst cout4", cout4, 0);
    chk("rst inv4", inv4, 0);    chk("rst busy1", busy1, 0);
    chk("rst sum1", sum1, 0);    chk("rst done1", done1, 0);
    rst4 = 1'b0; rst1 = 1'b0;

    run_op(4, 16'h1234, 16'h5678, 0, 0, "add1234");
    run_op(4, 16'h9999, 16'h0000, 0, 1, "ripple");
    run_op(4, 16'h0500, 16'h0123, 1, 0, "subpos");
    run_op(4, 16'h0123, 16'h0500, 1, 1, "subneg");
    run_op(4, 16'h12A4, 16'h0001, 0, 0, "badA");
    run_op(4, 16'h4321, 16'h00F0, 1, 0, "badB");
    run_op(4, 16'h9999, 16'h9999, 0, 1, "max");

    // A second start during ADD carries new operands and must be ignored.
    model(16'h2468, 16'h1357, 0, 1, 4, es, eco, einv);
    @(negedge clk);
    a = 16'h2468; b = 16'h1357; sub = 1'b0; cin = 1'b1; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); a = 16'h9999; b = 16'h9999; sub = 1'b1; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("restart done", done4, 1);
    chk("restart sum", sum4, es);
    chk("restart cout", cout4, eco);
    @(negedge clk);
    chk("restart noreaccept", busy4, 0);
    held4 = es;

    // Reset in the second ADD cycle aborts immediately and never produces done.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    chk("abort busy", busy4, 0); chk("abort done", done4, 0);
    chk("abort sum", sum4, 0);   chk("abort cout", cout4, 0);
    chk("abort inv", inv4, 0);
    held4 = '0;
    #1 rst4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort nodone", done4, 0);
    end
    run_op(4, 16'h0042, 16'h0058, 0, 0, "postrst");

    run_op(1, 16'h0007, 16'h0008, 0, 1, "d1 7+8+1");
    run_op(1, 16'h0009, 16'h0003, 1, 0, "d1 9-3");
    run_op(1, 16'h0002, 16'h0005, 1, 0, "d1 2-5");
    run_op(1, 16'h000B, 16'h0001, 0, 0, "d1 bad");

    for (int i = 0; i < 25; i++)
      run_op(4, rand_bcd(4, 1), rand_bcd(4, 1), 1'($urandom), 1'($urandom), "rand4");
    for (int i = 0; i < 12; i++)
      run_op(1, rand_bcd(1, 1), rand_bcd(1, 1), 1'($urandom), 1'($urandom), "rand1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
